alu_cmd_issuer: RTL and testbench

Initiator side of the 4-bit ALU interface. Accepts operation commands over a valid/ready handshake and drives the ALU operand and opcode ports. It captures the ALU result and flags one cycle later and returns them over a valid/ready response channel. Also holds an accumulator usable as operand A, a sticky overflow bit and an operation counter, so upstream logic can chain ALU operations without the ALU having any state of its own.

---
 rtl/alu_cmd_issuer.sv | 219 +++++++++++++++++++++
 tb/tb_alu_cmd_issuer.sv | 356 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_cmd_issuer.sv
// -----------------------------------------------------------------------------
// alu_cmd_issuer
//
// Initiator side of the 4-bit ALU interface. A command is accepted over a
// valid/ready handshake. Its operands are registered onto the ALU ports. One
// cycle later, the ALU result and flags are captured and returned over a
// valid/ready response channel. The block also keeps three pieces of state so
// that upstream logic can chain operations on a stateless ALU:
//   - an accumulator, usable as operand A,
//   - a sticky overflow bit,
//   - a completed-operation counter.
//
// Handshake semantics (both channels): a transfer happens on a rising clock
// edge where valid and ready are both high. While valid is high and ready is
// low, the sender holds its payload stable. Ready never depends on the valid
// of the same channel.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   cmd_valid/ready     command handshake
//   cmd_opc/a/b         command opcode and operands
//   cmd_src_acc         take operand A from the accumulator
//   cmd_wr_acc          write the result into the accumulator on completion
//   alu_opc/a/b         registered drive to the ALU
//   alu_result/carry/zero/overflow
//                       ALU outputs, sampled in the EXEC cycle
//   rsp_valid/ready     response handshake
//   rsp_result/carry/zero/overflow
//                       captured ALU outputs
//   acc                 accumulator
//   sticky_ovf          OR of captured overflow flags since reset or clear
//   op_cnt              completed operations, wraps
//   clr_status          synchronous clear of sticky_ovf and op_cnt
//   dbg_state           current FSM state (0 IDLE, 1 EXEC, 2 RESP)
// -----------------------------------------------------------------------------
module alu_cmd_issuer #(
    parameter int WIDTH = 4,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,

    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [2:0]       cmd_opc,
    input  logic [WIDTH-1:0] cmd_a,
    input  logic [WIDTH-1:0] cmd_b,
    input  logic             cmd_src_acc,
    input  logic             cmd_wr_acc,

    output logic [2:0]       alu_opc,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    input  logic [WIDTH-1:0] alu_result,
    input  logic             alu_carry,
    input  logic             alu_zero,
    input  logic             alu_overflow,

    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_result,
    output logic             rsp_carry,
    output logic             rsp_zero,
    output logic             rsp_overflow,

    output logic [WIDTH-1:0] acc,
    output logic             sticky_ovf,
    output logic [CNT_W-1:0] op_cnt,
    input  logic             clr_status,

    output logic [1:0]       dbg_state
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t state;
    state_t state_nxt;

    logic   cmd_fire;   // command handshake completes on this edge
    logic   in_exec;    // ALU outputs are valid for the latched command
    logic   wr_acc_q;   // write-back request of the command in flight

    // -------------------------------------------------------------------------
    // FSM: state register
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // -------------------------------------------------------------------------
    // FSM: next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (cmd_valid) begin
                    state_nxt = EXEC;
                end
            end
            EXEC: begin
                state_nxt = RESP;
            end
            RESP: begin
                // The response leaves on rsp_ready. A command offered in the
                // same cycle is taken at once, which keeps one op per 2 cycles.
                if (rsp_ready) begin
                    state_nxt = cmd_valid ? EXEC : IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // FSM: outputs
    // -------------------------------------------------------------------------
    always_comb begin
        cmd_ready = 1'b0;
        rsp_valid = 1'b0;
        in_exec   = 1'b0;
        case (state)
            IDLE: begin
                cmd_ready = 1'b1;
            end
            EXEC: begin
                in_exec = 1'b1;
            end
            RESP: begin
                rsp_valid = 1'b1;
                // A new command is only taken when the current response
                // leaves, so the response registers are never overwritten early.
                cmd_ready = rsp_ready;
            end
            default: begin
                cmd_ready = 1'b0;
            end
        endcase
        cmd_fire  = cmd_valid && cmd_ready;
        dbg_state = state;
    end

    // -------------------------------------------------------------------------
    // Operand registers driving the ALU. These change only on acceptance, so
    // the ALU inputs are stable throughout EXEC and RESP. In RESP, acc already
    // holds the write-back of the previous op, so chaining sees the new value.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alu_opc  <= 3'd0;
            alu_a    <= '0;
            alu_b    <= '0;
            wr_acc_q <= 1'b0;
        end else if (cmd_fire) begin
            alu_opc  <= cmd_opc;
            alu_a    <= cmd_src_acc ? acc : cmd_a;
            alu_b    <= cmd_b;
            wr_acc_q <= cmd_wr_acc;
        end
    end

    // -------------------------------------------------------------------------
    // Response capture. The flags pass through untouched. The registers are
    // loaded only at the end of EXEC, so they hold while RESP is stalled.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_result   <= '0;
            rsp_carry    <= 1'b0;
            rsp_zero     <= 1'b0;
            rsp_overflow <= 1'b0;
        end else if (in_exec) begin
            rsp_result   <= alu_result;
            rsp_carry    <= alu_carry;
            rsp_zero     <= alu_zero;
            rsp_overflow <= alu_overflow;
        end
    end

    // -------------------------------------------------------------------------
    // Accumulator write-back
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc <= '0;
        end else if (in_exec && wr_acc_q) begin
            acc <= alu_result;
        end
    end

    // -------------------------------------------------------------------------
    // Status: sticky overflow and operation counter. When clr_status lands in
    // the EXEC cycle, the clear is applied first and the completing op is then
    // counted on top. The op is therefore never lost from the statistics.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sticky_ovf <= 1'b0;
            op_cnt     <= '0;
        end else if (in_exec) begin
            sticky_ovf <= (clr_status ? 1'b0 : sticky_ovf) | alu_overflow;
            op_cnt     <= (clr_status ? '0 : op_cnt) + CNT_W'(1);
        end else if (clr_status) begin
            sticky_ovf <= 1'b0;
            op_cnt     <= '0;
        end
    end

endmodule

// File: tb/tb_alu_cmd_issuer.sv
// -----------------------------------------------------------------------------
// tb_alu_cmd_issuer
//
// Bench for alu_cmd_issuer with a behavioural 4-bit ALU attached. The model
// follows the observable rules of the block:
//   - a command accepted on an edge completes on the following edge,
//   - then it is answered until rsp_ready,
//   - the accumulator, sticky bit and counter update at completion.
// Expected responses are queued at acceptance. A separate monitor pops a
// response from the queue on every response handshake and compares it.
// -----------------------------------------------------------------------------
module tb_alu_cmd_issuer;

    localparam int W  = 4;
    localparam int CW = 8;

    // ---------------- clock / reset ----------------
    logic clk;
    logic rst_n;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- DUT signals ----------------
    logic          cmd_valid, cmd_ready;
    logic [2:0]    cmd_opc;
    logic [W-1:0]  cmd_a, cmd_b;
    logic          cmd_src_acc, cmd_wr_acc;
    logic [2:0]    alu_opc;
    logic [W-1:0]  alu_a, alu_b, alu_result;
    logic          alu_carry, alu_zero, alu_overflow;
    logic          rsp_valid, rsp_ready;
    logic [W-1:0]  rsp_result;
    logic          rsp_carry, rsp_zero, rsp_overflow;
    logic [W-1:0]  acc;
    logic          sticky_ovf;
    logic [CW-1:0] op_cnt;
    logic          clr_status;
    logic [1:0]    dbg_state;

    alu_cmd_issuer #(.WIDTH(W), .CNT_W(CW)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .cmd_valid    (cmd_valid),
        .cmd_ready    (cmd_ready),
        .cmd_opc      (cmd_opc),
        .cmd_a        (cmd_a),
        .cmd_b        (cmd_b),
        .cmd_src_acc  (cmd_src_acc),
        .cmd_wr_acc   (cmd_wr_acc),
        .alu_opc      (alu_opc),
        .alu_a        (alu_a),
        .alu_b        (alu_b),
        .alu_result   (alu_result),
        .alu_carry    (alu_carry),
        .alu_zero     (alu_zero),
        .alu_overflow (alu_overflow),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .rsp_result   (rsp_result),
        .rsp_carry    (rsp_carry),
        .rsp_zero     (rsp_zero),
        .rsp_overflow (rsp_overflow),
        .acc          (acc),
        .sticky_ovf   (sticky_ovf),
        .op_cnt       (op_cnt),
        .clr_status   (clr_status),
        .dbg_state    (dbg_state)
    );

    // ---------------- behavioural ALU: returns {ovf, zero, carry, result} ----
    function automatic logic [6:0] alu_ref(input logic [2:0] opc,
                                           input logic [3:0] a,
                                           input logic [3:0] b);
        int sa, sb, s;
        logic [3:0] r;
        logic c, z, v;
        sa = (a >= 8) ? int'(a) - 16 : int'(a);
        sb = (b >= 8) ? int'(b) - 16 : int'(b);
        c = 1'b0; z = 1'b0; v = 1'b0; r = 4'd0;
        case (opc)
            3'd0: begin
                s = int'(a) + int'(b);
                r = 4'(s);
                c = (s > 15);
                z = (r == 4'd0);
                v = (sa + sb > 7) || (sa + sb < -8);
            end
            3'd1: begin
                s = int'(a) + (15 - int'(b)) + 1;
                r = 4'(s);
                c = (s > 15);
                z = (r == 4'd0);
                v = (sa - sb > 7) || (sa - sb < -8);
            end
            3'd2: r = ~a;
            3'd3: r = a & b;
            3'd4: r = a | b;
            3'd5: r = a ^ b;
            3'd6: r = (sa < sb) ? 4'd1 : 4'd0;
            default: r = (a == b) ? 4'd1 : 4'd0;
        endcase
        return {v, z, c, r};
    endfunction

    always_comb begin
        {alu_overflow, alu_zero, alu_carry, alu_result} = alu_ref(alu_opc, alu_a, alu_b);
    end

    // ---------------- scoreboard ----------------
    int n_checks = 0;
    int n_errors = 0;

    // entry = {acc after op, ovf, zero, carry, result}
    logic [10:0] exp_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model (cycle rules) ----------------
    logic [W-1:0]  m_acc;
    logic          m_sticky;
    logic [CW-1:0] m_cnt;
    logic          m_in_exec;    // command accepted on the previous edge
    logic          m_rsp_valid;
    logic          m_pend_ovf;
    logic [2:0]    m_alu_opc;
    logic [W-1:0]  m_alu_a, m_alu_b;

    always @(negedge clk) begin : model
        logic       exp_ready, fire, rfire;
        logic [3:0] opa;
        logic [6:0] r;
        if (!rst_n) begin
            check("rst_rsp_valid",  32'(rsp_valid),  32'd0);
            check("rst_rsp_result", 32'(rsp_result), 32'd0);
            check("rst_acc",        32'(acc),        32'd0);
            check("rst_op_cnt",     32'(op_cnt),     32'd0);
            check("rst_sticky",     32'(sticky_ovf), 32'd0);
            check("rst_alu_opc",    32'(alu_opc),    32'd0);
            check("rst_alu_a",      32'(alu_a),      32'd0);
            check("rst_alu_b",      32'(alu_b),      32'd0);
            m_acc = '0; m_sticky = 1'b0; m_cnt = '0; m_in_exec = 1'b0;
            m_rsp_valid = 1'b0; m_pend_ovf = 1'b0;
            m_alu_opc = '0; m_alu_a = '0; m_alu_b = '0;
            exp_q.delete();
        end else begin
            exp_ready = m_in_exec ? 1'b0 : (m_rsp_valid ? rsp_ready : 1'b1);
            check("cmd_ready",  32'(cmd_ready),  32'(exp_ready));
            check("rsp_valid",  32'(rsp_valid),  32'(m_rsp_valid));
            check("op_cnt",     32'(op_cnt),     32'(m_cnt));
            check("sticky_ovf", 32'(sticky_ovf), 32'(m_sticky));
            check("alu_ports",  32'({alu_opc, alu_a, alu_b}), 32'({m_alu_opc, m_alu_a, m_alu_b}));

            // effects of the coming rising edge
            fire  = cmd_valid && exp_ready;
            rfire = m_rsp_valid && rsp_ready;
            if (m_in_exec) begin
                m_cnt       = (clr_status ? 8'd0 : m_cnt) + 8'd1;
                m_sticky    = (clr_status ? 1'b0 : m_sticky) | m_pend_ovf;
                m_rsp_valid = 1'b1;
                m_in_exec   = 1'b0;
            end else begin
                if (clr_status) begin
                    m_cnt    = '0;
                    m_sticky = 1'b0;
                end
                if (rfire) m_rsp_valid = 1'b0;
            end
            if (fire) begin
                opa = cmd_src_acc ? m_acc : cmd_a;
                r = alu_ref(cmd_opc, opa, cmd_b);
                if (cmd_wr_acc) m_acc = r[3:0];
                exp_q.push_back({m_acc, r});
                m_pend_ovf = r[6];
                m_alu_opc = cmd_opc; m_alu_a = opa; m_alu_b = cmd_b;
                m_in_exec = 1'b1;
            end
        end
    end

    // ---------------- response monitor ----------------
    logic       held_v;
    logic [6:0] held_rsp;

    always @(negedge clk) begin : monitor
        logic [10:0] e;
        if (!rst_n) begin
            held_v = 1'b0;
        end else begin
            if (held_v) begin
                check("rsp_stable", 32'({rsp_valid, rsp_overflow, rsp_zero, rsp_carry, rsp_result}),
                      32'({1'b1, held_rsp}));
            end
            held_v   = rsp_valid && !rsp_ready;
            held_rsp = {rsp_overflow, rsp_zero, rsp_carry, rsp_result};
            if (rsp_valid && rsp_ready) begin
                if (exp_q.size() == 0) begin
                    check("rsp_unexpected", 32'd1, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    check("rsp_result",   32'(rsp_result),   32'(e[3:0]));
                    check("rsp_carry",    32'(rsp_carry),    32'(e[4]));
                    check("rsp_zero",     32'(rsp_zero),     32'(e[5]));
                    check("rsp_overflow", 32'(rsp_overflow), 32'(e[6]));
                    check("rsp_acc",      32'(acc),          32'(e[10:7]));
                end
            end
        end
    end

    // ---------------- random rsp_ready / clr_status drivers ----------------
    logic rr_rand, clr_rand;

    always @(posedge clk) begin
        #1;
        if (rr_rand)  rsp_ready  = ($urandom_range(0, 3) != 0);
        if (clr_rand) clr_status = ($urandom_range(0, 7) == 0);
    end

    // ---------------- driver tasks ----------------
    task automatic issue(input logic [2:0] opc, input logic [3:0] a, input logic [3:0] b,
                         input logic src, input logic wr);
        logic fired;
        fired = 1'b0;
        cmd_valid = 1'b1; cmd_opc = opc; cmd_a = a; cmd_b = b;
        cmd_src_acc = src; cmd_wr_acc = wr;
        for (int i = 0; i < 64; i++) begin
            @(negedge clk);
            if (cmd_ready) begin
                fired = 1'b1;
                break;
            end
        end
        if (!fired) check("cmd_accept_timeout", 32'd0, 32'd1);
        @(posedge clk); #1;
        // junk while idle: must be ignored
        cmd_valid = 1'b0;
        cmd_opc = 3'($urandom); cmd_a = 4'($urandom); cmd_b = 4'($urandom);
        cmd_src_acc = 1'($urandom); cmd_wr_acc = 1'($urandom);
    endtask

    task automatic idle_cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #2000000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- main stimulus ----------------
    initial begin
        rst_n = 1'b0; cmd_valid = 1'b0; cmd_opc = '0; cmd_a = '0; cmd_b = '0;
        cmd_src_acc = 1'b0; cmd_wr_acc = 1'b0; rsp_ready = 1'b1; clr_status = 1'b0;
        rr_rand = 1'b0; clr_rand = 1'b0;
        idle_cycles(3);
        rst_n = 1'b1;
        idle_cycles(1);

        // add wrap: 7 + 9 -> 0, carry, zero; acc = 0
        issue(3'd0, 4'd7, 4'd9, 1'b0, 1'b1);
        idle_cycles(3);
        // sticky overflow then AND keeps it
        issue(3'd0, 4'd7, 4'd1, 1'b0, 1'b0);
        issue(3'd3, 4'hF, 4'd3, 1'b0, 1'b0);
        idle_cycles(3);
        @(negedge clk);
        check("sticky_after_and", 32'(sticky_ovf), 32'd1);
        idle_cycles(1);

        // accumulator chain
        issue(3'd0, 4'd3, 4'd0, 1'b0, 1'b1);
        issue(3'd0, 4'd0, 4'd4, 1'b1, 1'b1);
        issue(3'd5, 4'd0, 4'hF, 1'b1, 1'b0);
        issue(3'd1, 4'd0, 4'd7, 1'b1, 1'b0);
        idle_cycles(3);
        @(negedge clk);
        check("acc_chain", 32'(acc), 32'd7);
        idle_cycles(1);

        // backpressure: response held while a command waits
        rsp_ready = 1'b0;
        issue(3'd0, 4'd1, 4'd2, 1'b0, 1'b0);
        cmd_valid = 1'b1; cmd_opc = 3'd5; cmd_a = 4'd6; cmd_b = 4'd3;
        cmd_src_acc = 1'b0; cmd_wr_acc = 1'b0;
        idle_cycles(1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("bp_cmd_ready_low", 32'(cmd_ready), 32'd0);
        end
        @(posedge clk); #1;
        rsp_ready = 1'b1;
        issue(3'd5, 4'd6, 4'd3, 1'b0, 1'b0);
        idle_cycles(3);

        // clear in the EXEC cycle of 7+1
        issue(3'd0, 4'd7, 4'd1, 1'b0, 1'b0);
        clr_status = 1'b1;
        idle_cycles(1);
        clr_status = 1'b0;
        @(negedge clk);
        check("clr_exec_cnt",    32'(op_cnt),     32'd1);
        check("clr_exec_sticky", 32'(sticky_ovf), 32'd1);
        idle_cycles(1);

        // 255 more ops -> counter wraps to 0
        for (int i = 0; i < 255; i++) begin
            issue(3'($urandom_range(2, 7)), 4'($urandom), 4'($urandom), 1'($urandom), 1'($urandom));
        end
        idle_cycles(3);
        @(negedge clk);
        check("op_cnt_wrap", 32'(op_cnt), 32'd0);
        idle_cycles(1);

        // reset while a response is pending
        rsp_ready = 1'b0;
        issue(3'd0, 4'd5, 4'd5, 1'b0, 1'b1);
        idle_cycles(1);
        @(negedge clk);
        check("pre_reset_rsp_valid", 32'(rsp_valid), 32'd1);
        @(posedge clk); #1;
        rst_n = 1'b0;
        idle_cycles(2);
        rst_n = 1'b1;
        rsp_ready = 1'b1;
        @(negedge clk);
        check("post_reset_cmd_ready", 32'(cmd_ready), 32'd1);
        idle_cycles(1);

        // random traffic with random backpressure and clears
        rr_rand = 1'b1; clr_rand = 1'b1;
        for (int i = 0; i < 300; i++) begin
            issue(3'($urandom), 4'($urandom), 4'($urandom), 1'($urandom), 1'($urandom));
            if ($urandom_range(0, 3) == 0) idle_cycles($urandom_range(1, 3));
        end
        rr_rand = 1'b0; clr_rand = 1'b0;
        idle_cycles(1);
        rsp_ready = 1'b1; clr_status = 1'b0;
        idle_cycles(5);
        @(negedge clk);
        check("drain_queue_empty", 32'(exp_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
